// File: rtl/ex_forward_tracker_if.sv
// Execute-stage forwarding bundle: EX-stage operands/results in, pipeline results and
// forwarding controls out. The tracker is the slave; the core/bench is the master.
interface ex_forward_tracker_if #(
  parameter int unsigned WORD_LENGTH = 8,
  parameter int unsigned REG_ADDR_W  = 3
);
  logic [REG_ADDR_W-1:0]  exRs1;
  logic [REG_ADDR_W-1:0]  exRs2;
  logic                   exUsesRs2;
  logic [REG_ADDR_W-1:0]  exRd;
  logic                   exRegWrite;
  logic                   exMemRead;
  logic [WORD_LENGTH-1:0] exAluResult;
  logic [WORD_LENGTH-1:0] memReadData;
  logic                   flush;

  logic [WORD_LENGTH-1:0] Ex_Mem_aluResult;
  logic [WORD_LENGTH-1:0] Mem_Wb_aluResult;
  logic [REG_ADDR_W-1:0]  Mem_Wb_rd;
  logic                   Mem_Wb_regWrite;
  logic [1:0]             aluInputAForwardingSel;
  logic [1:0]             aluInputBForwardingSel;
  logic                   loadUseStall;

  modport master (
    output exRs1, exRs2, exUsesRs2, exRd, exRegWrite, exMemRead, exAluResult, memReadData,
           flush,
    input  Ex_Mem_aluResult, Mem_Wb_aluResult, Mem_Wb_rd, Mem_Wb_regWrite,
           aluInputAForwardingSel, aluInputBForwardingSel, loadUseStall
  );

  modport slave (
    input  exRs1, exRs2, exUsesRs2, exRd, exRegWrite, exMemRead, exAluResult, memReadData,
           flush,
    output Ex_Mem_aluResult, Mem_Wb_aluResult, Mem_Wb_rd, Mem_Wb_regWrite,
           aluInputAForwardingSel, aluInputBForwardingSel, loadUseStall
  );
endinterface

// File: rtl/ex_forward_tracker.sv
// EX/MEM and MEM/WB result registers, write-back port, ALU forwarding selects and
// load-use stall detection for the 8-bit pipelined core.
module ex_forward_tracker #(
  parameter int unsigned WORD_LENGTH = 8,
  parameter int unsigned REG_ADDR_W  = 3
) (
  input logic                clk,
  input logic                rst,
  ex_forward_tracker_if.slave bus
);
  localparam logic [1:0] SelReg   = 2'd0;
  localparam logic [1:0] SelExMem = 2'd1;
  localparam logic [1:0] SelMemWb = 2'd2;

  logic [REG_ADDR_W-1:0]  r_exmem_rd;
  logic                   r_exmem_regwrite;
  logic                   r_exmem_memread;
  logic [WORD_LENGTH-1:0] r_exmem_result;
  logic [REG_ADDR_W-1:0]  r_memwb_rd;
  logic                   r_memwb_regwrite;
  logic [WORD_LENGTH-1:0] r_memwb_value;

  logic       w_exmem_fwd_ok;
  logic       w_memwb_fwd_ok;
  logic       w_load_pending;
  logic       w_stall;
  logic       w_bubble;
  logic [1:0] w_sel_a;
  logic [1:0] w_sel_b;

  // A load in EX/MEM has no data yet, so it can only stall, never forward from EX/MEM.
  assign w_exmem_fwd_ok = r_exmem_regwrite & ~r_exmem_memread & (r_exmem_rd != '0);
  assign w_memwb_fwd_ok = r_memwb_regwrite & (r_memwb_rd != '0);
  assign w_load_pending = r_exmem_memread & r_exmem_regwrite & (r_exmem_rd != '0);

  assign w_stall  = w_load_pending & ~bus.flush &
                    ((r_exmem_rd == bus.exRs1) | (bus.exUsesRs2 & (r_exmem_rd == bus.exRs2)));
  assign w_bubble = bus.flush | w_stall;

  always_comb begin
    w_sel_a = SelReg;
    if (w_exmem_fwd_ok && (r_exmem_rd == bus.exRs1)) begin
      w_sel_a = SelExMem;
    end else if (w_memwb_fwd_ok && (r_memwb_rd == bus.exRs1)) begin
      w_sel_a = SelMemWb;
    end
  end

  always_comb begin
    w_sel_b = SelReg;
    if (bus.exUsesRs2) begin
      if (w_exmem_fwd_ok && (r_exmem_rd == bus.exRs2)) begin
        w_sel_b = SelExMem;
      end else if (w_memwb_fwd_ok && (r_memwb_rd == bus.exRs2)) begin
        w_sel_b = SelMemWb;
      end
    end
  end

  // Bubbles keep the previous result so the EX/MEM data path does not toggle needlessly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_exmem_rd       <= '0;
      r_exmem_regwrite <= 1'b0;
      r_exmem_memread  <= 1'b0;
      r_exmem_result   <= '0;
    end else if (w_bubble) begin
      r_exmem_rd       <= '0;
      r_exmem_regwrite <= 1'b0;
      r_exmem_memread  <= 1'b0;
    end else begin
      r_exmem_rd       <= bus.exRd;
      r_exmem_regwrite <= bus.exRegWrite;
      r_exmem_memread  <= bus.exMemRead;
      r_exmem_result   <= bus.exAluResult;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_memwb_rd       <= '0;
      r_memwb_regwrite <= 1'b0;
      r_memwb_value    <= '0;
    end else begin
      r_memwb_rd       <= r_exmem_rd;
      r_memwb_regwrite <= r_exmem_regwrite;
      r_memwb_value    <= r_exmem_memread ? bus.memReadData : r_exmem_result;
    end
  end

  assign bus.Ex_Mem_aluResult       = r_exmem_result;
  assign bus.Mem_Wb_aluResult       = r_memwb_value;
  assign bus.Mem_Wb_rd              = r_memwb_rd;
  assign bus.Mem_Wb_regWrite        = r_memwb_regwrite;
  assign bus.aluInputAForwardingSel = w_sel_a;
  assign bus.aluInputBForwardingSel = w_sel_b;
  assign bus.loadUseStall           = w_stall;
endmodule

// File: tb/tb_ex_forward_tracker.sv
// Self-checking bench for ex_forward_tracker: directed scenarios plus random stimulus
// against an instruction-history model (newest issued instruction first).
module tb_ex_forward_tracker;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_forward_tracker_if #(.WORD_LENGTH(8), .REG_ADDR_W(3)) bus ();

  ex_forward_tracker #(.WORD_LENGTH(8), .REG_ADDR_W(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic       w;
    logic       ld;
    logic [2:0] rd;
    logic [7:0] val;
    logic [7:0] wb;
  } ent_t;

  // hist[0] = instruction issued one cycle ago, hist[1] = two cycles ago.
  ent_t hist[$];
  int n_checks = 0;
  int n_fails  = 0;

  task automatic model_reset();
    ent_t z;
    z = '0;
    hist.delete();
    hist.push_back(z);
    hist.push_back(z);
  endtask

  // Nearest older instruction that can supply rs; a load one cycle old has no data yet.
  function automatic logic [1:0] m_sel(input logic [2:0] rs);
    if (rs == 3'd0) return 2'd0;
    if (hist[0].w && !hist[0].ld && hist[0].rd == rs) return 2'd1;
    if (hist[1].w && hist[1].rd == rs) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic m_stall();
    if (bus.flush) return 1'b0;
    if (!(hist[0].ld && hist[0].w) || hist[0].rd == 3'd0) return 1'b0;
    return (hist[0].rd == bus.exRs1) || (bus.exUsesRs2 && hist[0].rd == bus.exRs2);
  endfunction

  task automatic set_in(input logic [2:0] rs1, input logic [2:0] rs2, input logic u2,
                        input logic [2:0] rd, input logic rw, input logic mr,
                        input logic [7:0] alu, input logic [7:0] mrd, input logic fl);
    bus.exRs1 = rs1; bus.exRs2 = rs2; bus.exUsesRs2 = u2;
    bus.exRd = rd; bus.exRegWrite = rw; bus.exMemRead = mr;
    bus.exAluResult = alu; bus.memReadData = mrd; bus.flush = fl;
    #1;
  endtask

  // Issue the instruction currently on the inputs and advance one clock.
  task automatic step();
    ent_t e;
    ent_t e0;
    logic st;
    st = m_stall();
    e0 = hist[0];
    e0.wb = e0.ld ? bus.memReadData : e0.val;
    hist[0] = e0;
    e = '0;
    if (bus.flush || st) begin
      e.val = e0.val;
    end else begin
      e.w = bus.exRegWrite; e.ld = bus.exMemRead; e.rd = bus.exRd; e.val = bus.exAluResult;
    end
    hist.push_front(e);
    void'(hist.pop_back());
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    n_checks++;
    if (bus.Mem_Wb_regWrite !== 1'b0 || bus.Ex_Mem_aluResult !== 8'h00 ||
        bus.loadUseStall !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_initial: wbwe=%b exmem=%h stall=%b want 0/00/0",
               bus.Mem_Wb_regWrite, bus.Ex_Mem_aluResult, bus.loadUseStall);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    set_in(3'd0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0, 8'hA7, 8'h00, 1'b0);
    step();
    step();
    set_in(3'd3, 3'd3, 1'b1, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    n_checks++;
    if (bus.aluInputAForwardingSel !== 2'd1 || bus.Mem_Wb_regWrite !== 1'b1) begin
      n_fails++;
      $display("FAIL reset_prestate: selA=%0d wbwe=%b want 1/1",
               bus.aluInputAForwardingSel, bus.Mem_Wb_regWrite);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.aluInputAForwardingSel !== 2'd0 || bus.aluInputBForwardingSel !== 2'd0 ||
        bus.Mem_Wb_regWrite !== 1'b0 || bus.Mem_Wb_rd !== 3'd0 ||
        bus.Mem_Wb_aluResult !== 8'h00 || bus.Ex_Mem_aluResult !== 8'h00 ||
        bus.loadUseStall !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_async: selA=%0d selB=%0d wbwe=%b rd=%0d wb=%h exmem=%h stall=%b want all 0",
               bus.aluInputAForwardingSel, bus.aluInputBForwardingSel, bus.Mem_Wb_regWrite,
               bus.Mem_Wb_rd, bus.Mem_Wb_aluResult, bus.Ex_Mem_aluResult, bus.loadUseStall);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_exmem_forward();
    set_in(3'd0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0, 8'h5A, 8'h00, 1'b0);
    step();
    set_in(3'd2, 3'd0, 1'b0, 3'd1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    n_checks++;
    if (bus.aluInputAForwardingSel !== 2'd1 || bus.Ex_Mem_aluResult !== 8'h5A) begin
      n_fails++;
      $display("FAIL exmem_forward: selA=%0d val=%h want 1/5a",
               bus.aluInputAForwardingSel, bus.Ex_Mem_aluResult);
    end
    step();
  endtask

  task automatic test_memwb_forward();
    set_in(3'd0, 3'd2, 1'b1, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    n_checks++;
    if (bus.aluInputBForwardingSel !== 2'd2 || bus.Mem_Wb_aluResult !== 8'h5A ||
        bus.Mem_Wb_rd !== 3'd2 || bus.Mem_Wb_regWrite !== 1'b1) begin
      n_fails++;
      $display("FAIL memwb_forward: selB=%0d wb=%h rd=%0d we=%b want 2/5a/2/1",
               bus.aluInputBForwardingSel, bus.Mem_Wb_aluResult, bus.Mem_Wb_rd,
               bus.Mem_Wb_regWrite);
    end
    set_in(3'd0, 3'd2, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    n_checks++;
    if (bus.aluInputBForwardingSel !== 2'd0) begin
      n_fails++;
      $display("FAIL memwb_no_rs2: selB=%0d want 0", bus.aluInputBForwardingSel);
    end
    step();
  endtask

  task automatic test_priority_r0();
    set_in(3'd0, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0, 8'h11, 8'h00, 1'b0);
    step();
    set_in(3'd0, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0, 8'h22, 8'h00, 1'b0);
    step();
    set_in(3'd4, 3'd4, 1'b1, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    n_checks++;
    if (bus.aluInputAForwardingSel !== 2'd1 || bus.aluInputBForwardingSel !== 2'd1 ||
        bus.Ex_Mem_aluResult !== 8'h22) begin
      n_fails++;
      $display("FAIL priority: selA=%0d selB=%0d val=%h want 1/1/22",
               bus.aluInputAForwardingSel, bus.aluInputBForwardingSel, bus.Ex_Mem_aluResult);
    end
    set_in(3'd0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0, 8'h77, 8'h00, 1'b0);
    step();
    set_in(3'd0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0, 8'h78, 8'h00, 1'b0);
    step();
    set_in(3'd0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    n_checks++;
    if (bus.aluInputAForwardingSel !== 2'd0 || bus.aluInputBForwardingSel !== 2'd0) begin
      n_fails++;
      $display("FAIL r0_no_forward: selA=%0d selB=%0d want 0/0",
               bus.aluInputAForwardingSel, bus.aluInputBForwardingSel);
    end
    step();
  endtask

  task automatic test_load_use();
    set_in(3'd0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b1, 8'h40, 8'h00, 1'b0);
    step();
    set_in(3'd5, 3'd1, 1'b1, 3'd7, 1'b1, 1'b0, 8'h99, 8'hC3, 1'b0);
    n_checks++;
    if (bus.loadUseStall !== 1'b1) begin
      n_fails++;
      $display("FAIL load_use_stall: stall=%b want 1", bus.loadUseStall);
    end
    step();
    n_checks++;
    if (bus.loadUseStall !== 1'b0 || bus.aluInputAForwardingSel !== 2'd2 ||
        bus.Mem_Wb_aluResult !== 8'hC3) begin
      n_fails++;
      $display("FAIL load_use_release: stall=%b selA=%0d wb=%h want 0/2/c3",
               bus.loadUseStall, bus.aluInputAForwardingSel, bus.Mem_Wb_aluResult);
    end
    step();
  endtask

  task automatic test_flush();
    set_in(3'd0, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0, 8'h66, 8'h00, 1'b1);
    step();
    set_in(3'd6, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    n_checks++;
    if (bus.aluInputAForwardingSel !== 2'd0) begin
      n_fails++;
      $display("FAIL flush_no_fwd: selA=%0d want 0", bus.aluInputAForwardingSel);
    end
    step();
    n_checks++;
    if (bus.Mem_Wb_regWrite !== 1'b0) begin
      n_fails++;
      $display("FAIL flush_wb: we=%b want 0", bus.Mem_Wb_regWrite);
    end
    set_in(3'd0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
    step();
    set_in(3'd5, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0, 8'h12, 8'h3C, 1'b1);
    n_checks++;
    if (bus.loadUseStall !== 1'b0) begin
      n_fails++;
      $display("FAIL flush_over_stall: stall=%b want 0", bus.loadUseStall);
    end
    step();
    set_in(3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    n_checks++;
    if (bus.Mem_Wb_regWrite !== 1'b1 || bus.Mem_Wb_rd !== 3'd5 ||
        bus.Mem_Wb_aluResult !== 8'h3C) begin
      n_fails++;
      $display("FAIL flush_load_wb: we=%b rd=%0d wb=%h want 1/5/3c",
               bus.Mem_Wb_regWrite, bus.Mem_Wb_rd, bus.Mem_Wb_aluResult);
    end
    step();
  endtask

  task automatic test_random();
    logic [1:0] ea;
    logic [1:0] eb;
    logic       es;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 400; i++) begin
      set_in(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 2) == 0), 8'($urandom), 8'($urandom),
             ($urandom_range(0, 7) == 0));
      ea = m_sel(bus.exRs1);
      eb = bus.exUsesRs2 ? m_sel(bus.exRs2) : 2'd0;
      es = m_stall();
      n_checks++;
      if (bus.aluInputAForwardingSel !== ea || bus.aluInputBForwardingSel !== eb ||
          bus.loadUseStall !== es) begin
        n_fails++;
        $display("FAIL rand_ctrl[%0d]: selA=%0d selB=%0d stall=%b want %0d/%0d/%b", i,
                 bus.aluInputAForwardingSel, bus.aluInputBForwardingSel, bus.loadUseStall,
                 ea, eb, es);
      end
      n_checks++;
      if (bus.Ex_Mem_aluResult !== hist[0].val || bus.Mem_Wb_aluResult !== hist[1].wb ||
          bus.Mem_Wb_rd !== hist[1].rd || bus.Mem_Wb_regWrite !== hist[1].w) begin
        n_fails++;
        $display("FAIL rand_data[%0d]: exmem=%h wb=%h rd=%0d we=%b want %h/%h/%0d/%b", i,
                 bus.Ex_Mem_aluResult, bus.Mem_Wb_aluResult, bus.Mem_Wb_rd,
                 bus.Mem_Wb_regWrite, hist[0].val, hist[1].wb, hist[1].rd, hist[1].w);
      end
      step();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_exmem_forward();
    test_memwb_forward();
    test_priority_r0();
    test_load_use();
    test_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
